// File: rtl/voice_pkg.sv
// Shared types and constants for the time-multiplexed voice generator.
// Holds the handshake FSM states, state widths, LFSR seed and waveform select bits.
package voice_pkg;

    localparam int ACC_W  = 24;
    localparam int LFSR_W = 23;
    localparam int WAVE_W = 10;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFF8;

    localparam int WAVE_TRI = 0;
    localparam int WAVE_SAW = 1;
    localparam int WAVE_PUL = 2;
    localparam int WAVE_NOI = 3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CALC,
        READY
    } state_e;

    // One shift of the 23-bit noise register (taps 22 and 17).
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[21:0], l[22] ^ l[17]};
    endfunction

endpackage

// File: rtl/voice_state_mem.sv
// Per-voice persistent state: phase accumulator and noise LFSR.
// One registered read port and one write port; every row resets to its start value.
module voice_state_mem
    import voice_pkg::*;
#(
    parameter int  NUM_VOICES = 16,
    localparam int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [ACC_W-1:0]  rd_acc,
    output logic [LFSR_W-1:0] rd_lfsr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [ACC_W-1:0]  wr_acc,
    input  logic [LFSR_W-1:0] wr_lfsr
);

    logic [ACC_W-1:0]  acc_q  [NUM_VOICES];
    logic [LFSR_W-1:0] lfsr_q [NUM_VOICES];

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_row
        logic [ACC_W-1:0]  acc_reg;
        logic [LFSR_W-1:0] lfsr_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                acc_reg  <= '0;
                lfsr_reg <= LFSR_SEED;
            end else if (wr_en && (wr_addr == IDX_W'(gi))) begin
                acc_reg  <= wr_acc;
                lfsr_reg <= wr_lfsr;
            end
        end

        assign acc_q[gi]  = acc_reg;
        assign lfsr_q[gi] = lfsr_reg;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_acc  <= '0;
            rd_lfsr <= LFSR_SEED;
        end else if (rd_en) begin
            rd_acc  <= acc_q[rd_addr];
            rd_lfsr <= lfsr_q[rd_addr];
        end
    end

endmodule

// File: rtl/voice_gen.sv
// Sixteen-voice waveform generator answering the controller's start/ready handshake.
// Each accepted start advances one voice's phase and noise state and returns its sample.
module voice_gen
    import voice_pkg::*;
#(
    parameter int  NUM_VOICES = 16,
    localparam int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              voice_start_i,
    input  logic [IDX_W-1:0]  voice_idx_i,
    input  logic [15:0]       voice_freq_i,
    input  logic [11:0]       voice_pw_i,
    input  logic [3:0]        voice_wave_i,
    output logic              voice_ready_o,
    output logic [WAVE_W-1:0] voice_wave_o
);

    state_e state_reg, state_next;

    logic [IDX_W-1:0]  idx_reg;
    logic [15:0]       freq_reg;
    logic [11:0]       pw_reg;
    logic [3:0]        wave_sel_reg;
    logic              ready_reg;
    logic [WAVE_W-1:0] wave_reg;

    logic [ACC_W-1:0]  rd_acc, acc_new;
    logic [LFSR_W-1:0] rd_lfsr, lfsr_new;
    logic [WAVE_W-1:0] shapes [4];
    logic [WAVE_W-1:0] wave_next;

    voice_state_mem #(
        .NUM_VOICES(NUM_VOICES)
    ) u_state_mem (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rd_en  (state_reg == READ),
        .rd_addr(idx_reg),
        .rd_acc (rd_acc),
        .rd_lfsr(rd_lfsr),
        .wr_en  (state_reg == CALC),
        .wr_addr(idx_reg),
        .wr_acc (acc_new),
        .wr_lfsr(lfsr_new)
    );

    // Noise advances only when the phase crosses upward through bit 19.
    assign acc_new  = rd_acc + {8'h00, freq_reg};
    assign lfsr_new = (!rd_acc[19] && acc_new[19]) ? lfsr_step(rd_lfsr) : rd_lfsr;

    assign shapes[WAVE_TRI] = acc_new[23] ? ~acc_new[22:13] : acc_new[22:13];
    assign shapes[WAVE_SAW] = acc_new[23:14];
    assign shapes[WAVE_PUL] = (acc_new[23:12] >= pw_reg) ? 10'h3FF : 10'h000;
    assign shapes[WAVE_NOI] = {lfsr_new[22], lfsr_new[20], lfsr_new[16], lfsr_new[13],
                               lfsr_new[11], lfsr_new[7], lfsr_new[4], lfsr_new[2], 2'b00};

    always_comb begin
        wave_next = '1;
        for (int i = 0; i < 4; i++) begin
            if (wave_sel_reg[i]) begin
                wave_next = wave_next & shapes[i];
            end
        end
        if (wave_sel_reg == 4'b0000) begin
            wave_next = '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (voice_start_i) state_next = READ;
            READ:    state_next = CALC;
            CALC:    state_next = READY;
            READY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            freq_reg     <= '0;
            pw_reg       <= '0;
            wave_sel_reg <= '0;
            ready_reg    <= 1'b0;
            wave_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && voice_start_i) begin
                idx_reg      <= voice_idx_i;
                freq_reg     <= voice_freq_i;
                pw_reg       <= voice_pw_i;
                wave_sel_reg <= voice_wave_i;
            end
            ready_reg <= (state_reg == CALC);
            if (state_reg == CALC) begin
                wave_reg <= wave_next;
            end
        end
    end

    assign voice_ready_o = ready_reg;
    assign voice_wave_o  = wave_reg;

endmodule

// File: tb/tb_voice_gen.sv
// Self-checking bench for voice_gen: a vector table plus hand-written sequences,
// with expected samples queued at each start and compared when ready arrives.
module tb_voice_gen;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       voice_start_i = 1'b0;
    logic [3:0] voice_idx_i = '0;
    logic [15:0] voice_freq_i = '0;
    logic [11:0] voice_pw_i = '0;
    logic [3:0] voice_wave_i = '0;
    logic       voice_ready_o;
    logic [9:0] voice_wave_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int    exp;
        string tag;
    } exp_t;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] freq;
        logic [11:0] pw;
        logic [3:0]  wave;
        int          exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[10];
    bit   prev_ready = 1'b0;

    voice_gen dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .voice_start_i(voice_start_i),
        .voice_idx_i  (voice_idx_i),
        .voice_freq_i (voice_freq_i),
        .voice_pw_i   (voice_pw_i),
        .voice_wave_i (voice_wave_i),
        .voice_ready_o(voice_ready_o),
        .voice_wave_o (voice_wave_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int unsigned acc_after(input int unsigned k, input int unsigned f);
        return (k * f) & 32'h00FF_FFFF;
    endfunction

    function automatic int saw_of(input int unsigned a);
        return int'((a >> 14) & 32'h3FF);
    endfunction

    function automatic int tri_of(input int unsigned a);
        int t;
        t = int'((a >> 13) & 32'h3FF);
        if (((a >> 23) & 32'h1) != 0) t = (~t) & 32'h3FF;
        return t;
    endfunction

    // Scoreboard: every ready pops one expectation (exp < 0 means value not checked).
    always @(negedge clk_i) begin
        exp_t e;
        if (voice_ready_o) begin
            checks++;
            if (prev_ready) begin
                failures++;
                $display("FAIL ready_pulse: ready high %0d cycles running, required 1", 2);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ready: ready=1 wave=%h, required no ready", voice_wave_o);
            end else begin
                e = exp_q.pop_front();
                if (e.exp >= 0 && voice_wave_o !== 10'(e.exp)) begin
                    failures++;
                    $display("FAIL %s: wave=%h required %h", e.tag, voice_wave_o, 10'(e.exp));
                end
            end
        end
        prev_ready = voice_ready_o;
    end

    task automatic issue(input logic [3:0] idx, input logic [15:0] f, input logic [11:0] pw,
                         input logic [3:0] w, input int e, input string tag);
        int   cnt;
        bit   got;
        exp_t dummy;
        @(negedge clk_i);
        voice_idx_i   = idx;
        voice_freq_i  = f;
        voice_pw_i    = pw;
        voice_wave_i  = w;
        voice_start_i = 1'b1;
        exp_q.push_back('{exp: e, tag: tag});
        @(negedge clk_i);
        voice_start_i = 1'b0;
        cnt = 1;
        got = voice_ready_o;
        while (!got && cnt < 8) begin
            @(negedge clk_i);
            cnt++;
            got = voice_ready_o;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout: no ready after %0d cycles, required ready at 3", tag, cnt);
            dummy = exp_q.pop_back();
        end else if (cnt != 3) begin
            failures++;
            $display("FAIL %s_latency: ready after %0d cycles, required 3", tag, cnt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int e;

        // Fresh voices 5 and 6; expected samples derived by hand from the waveform rules.
        vecs[0] = '{4'd5, 16'h4000, 12'h000, 4'b0010, 1};
        vecs[1] = '{4'd5, 16'h4000, 12'h000, 4'b0001, 4};
        vecs[2] = '{4'd5, 16'h4000, 12'h000, 4'b0100, 10'h3FF};
        vecs[3] = '{4'd5, 16'h0000, 12'h00D, 4'b0100, 0};
        vecs[4] = '{4'd5, 16'h0000, 12'h00C, 4'b0100, 10'h3FF};
        vecs[5] = '{4'd5, 16'h0000, 12'h000, 4'b0000, 0};
        vecs[6] = '{4'd5, 16'h0000, 12'h000, 4'b1000, 10'h3F8};
        vecs[7] = '{4'd5, 16'h0000, 12'h000, 4'b0110, 3};
        vecs[8] = '{4'd6, 16'hFFFF, 12'h000, 4'b0001, 7};
        vecs[9] = '{4'd6, 16'h0000, 12'h000, 4'b0111, 3};

        repeat (3) @(negedge clk_i);
        checks++;
        if (voice_ready_o !== 1'b0 || voice_wave_o !== 10'h000) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b wave=%h required 0 000", voice_ready_o, voice_wave_o);
        end
        rst_ni = 1'b1;

        for (int i = 0; i < 10; i++) issue(vecs[i].idx, vecs[i].freq, vecs[i].pw, vecs[i].wave,
                                            vecs[i].exp, $sformatf("vec%0d", i));

        for (int k = 1; k <= 16; k++) issue(4'd3, 16'h4000, 12'h000, 4'b0010, k, "saw_count");
        issue(4'd4, 16'h0000, 12'h000, 4'b0010, 0, "voice_isolation");

        for (int k = 1; k <= 257; k++)
            issue(4'd0, 16'hFFFF, 12'h000, 4'b0010, saw_of(acc_after(k, 32'hFFFF)), "saw_wrap");

        for (int k = 1; k <= 64; k++)
            issue(4'd1, 16'hFFFF, 12'h000, 4'b0001, tri_of(acc_after(k, 32'hFFFF)), "tri_ramp");
        issue(4'd1, 16'hFFFF, 12'h000, 4'b0011, 10'h003, "tri_and_saw");
        issue(4'd1, 16'hFFFF, 12'h000, 4'b0000, 0, "no_wave");

        for (int k = 1; k <= 8; k++) issue(4'd2, 16'h1234, 12'h000, 4'b0100, 10'h3FF, "pulse_pw0");
        for (int k = 1; k <= 1000; k++) issue(4'd7, 16'h0100, 12'hFFF, 4'b0100, 0, "pulse_pwmax");

        for (int k = 1; k <= 144; k++) begin
            if (k <= 15) e = 10'h3F8;
            else if (k >= 112 && k <= 143) e = 10'h3F0;
            else if (k == 144) e = 10'h3E0;
            else e = -1;
            issue(4'd8, 16'h8000, 12'h000, 4'b1000, e, "noise");
        end

        // Start held through READ/CALC/READY: only the first one may be accepted.
        @(negedge clk_i);
        voice_idx_i = 4'd9; voice_freq_i = 16'h4000; voice_pw_i = 12'h000; voice_wave_i = 4'b0010;
        voice_start_i = 1'b1;
        exp_q.push_back('{exp: 1, tag: "ignore_first"});
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (voice_ready_o) cnt++;
            if (i == 4) voice_start_i = 1'b0;
        end
        checks++;
        if (cnt != 1) begin
            failures++;
            $display("FAIL ignore_start: %0d readies, required 1", cnt);
        end
        issue(4'd9, 16'h4000, 12'h000, 4'b0010, 2, "ignore_advance_once");

        // Reset asserted while the request sits in CALC.
        @(negedge clk_i);
        voice_idx_i = 4'd10; voice_freq_i = 16'h4000; voice_wave_i = 4'b0010;
        voice_start_i = 1'b1;
        @(negedge clk_i);
        voice_start_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++;
            if (voice_ready_o !== 1'b0 || voice_wave_o !== 10'h000) begin
                failures++;
                $display("FAIL reset_abort: ready=%b wave=%h required 0 000", voice_ready_o, voice_wave_o);
            end
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        issue(4'd10, 16'h4000, 12'h000, 4'b0010, 1, "saw_after_reset");
        issue(4'd3, 16'h0000, 12'h000, 4'b0010, 0, "acc_cleared");
        issue(4'd8, 16'h0000, 12'h000, 4'b1000, 10'h3F8, "lfsr_reseeded");

        repeat (4) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_gen.md
# voice_gen

Sixteen-voice time-multiplexed waveform generator serving as the responder on the controller's voice-generation handshake. On each accepted start pulse it updates the selected voice's persistent phase accumulator and noise LFSR, computes the selected 10-bit waveform, and returns it with a one-cycle ready pulse. The controller runs it once per voice per 50 kHz sample tick.

## Interface
- NUM_VOICES, 16, number of voices held in internal state
- ACC_W, 24, phase accumulator width
- clk_i  in  1  50 MHz clock
- rst_ni  in  1  reset, asynchronous, active-low
- voice_start_i  in  1  start request, single-cycle pulse
- voice_idx_i  in  $clog2(NUM_VOICES)  voice index, sampled with start
- voice_freq_i  in  16  phase increment, sampled with start
- voice_pw_i  in  12  pulse-width compare value, sampled with start
- voice_wave_i  in  4  waveform select, sampled with start: [0] triangle, [1] sawtooth, [2] pulse, [3] noise
- voice_ready_o  out  1  result valid, one-cycle pulse
- voice_wave_o  out  10  unsigned waveform sample

## Operation
- FSM states: IDLE, READ, CALC, READY.
- IDLE: on voice_start_i, latch idx/freq/pw/wave, go to READ. Otherwise stay.
- READ: registered fetch of acc[idx] and lfsr[idx].
- CALC: compute acc_new = acc + zero-extended freq, mod 2^24. Write acc_new back.
  - If acc[19]==0 and acc_new[19]==1, step the LFSR once and write it back. Otherwise write back unchanged.
  - Compute the waveforms from acc_new and the post-step LFSR, then register voice_wave_o.
- READY: voice_ready_o=1 for this cycle only. Return to IDLE.
- voice_start_i in READ/CALC/READY is ignored.
- Waveforms:
  - saw = acc_new[23:14]
  - tri = acc_new[23] ? ~acc_new[22:13] : acc_new[22:13]
  - pulse = (acc_new[23:12] >= pw) ? 10'h3FF : 10'h000
  - noise = {lfsr[22],lfsr[20],lfsr[16],lfsr[13],lfsr[11],lfsr[7],lfsr[4],lfsr[2],2'b00}
- Combining selected waveforms:
  - Output is the bitwise AND of all selected waveforms.
  - wave_i==4'b0000 gives 10'h000.
- LFSR: 23-bit. Step is lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}.
- Reset values:
  - All acc = 0.
  - All lfsr = 23'h7FFFF8.
  - State IDLE.
  - voice_ready_o = 0, voice_wave_o = 0.
- Reset mid-operation aborts the request. No ready is issued. Arrays return to their reset values.
- voice_wave_o holds its value from READY until the next CALC.

## Timing
- Start high in cycle N gives ready and the wave in cycle N+3.
- voice_ready_o is registered and never high two consecutive cycles.
- Earliest next accepted start is cycle N+4.
- 16 voices take ≤ 16×(3+controller turnaround) cycles, far below the 1000-cycle sample period.
- Each voice has exactly one write-back per accepted start. No read/write hazard, because requests are serialized.

## Structure
- voice_pkg holds:
  - state enum
  - ACC_W and LFSR_W
  - LFSR_SEED = 23'h7FFFF8
  - waveform select bit positions WAVE_TRI/SAW/PUL/NOI
- One sub-module, voice_state_mem:
  - NUM_VOICES × (ACC_W+23) register array
  - one registered read port, one write port
  - asynchronous reset to the reset values above
- Waveform shaping is inline combinational logic in voice_gen.

## Test plan
- Sawtooth count: voice 3, freq 16'h4000, wave 4'b0010, 16 starts → ready at N+3 each time. wave_o = 1,2,…,16. A start on voice 4 with freq 0 then gives 0, showing voices are isolated.
- Wrap-around: voice 0, freq 16'hFFFF, saw, 257 starts → acc = 24'h00FEFF, wave_o = 3. The previous start (step 256) gives 10'h3FF.
- Triangle and combination: freq 16'hFFFF.
  - After 64 starts with tri → 10'h1FF.
  - Same voice, next start (step 65) with wave 4'b0011 → the AND of tri and saw for acc 24'h40FFBF.
  - wave 4'b0000 → 10'h000.
- Pulse boundary:
  - pw 12'h000 → 10'h3FF always.
  - pw 12'hFFF with freq 16'h0100 → 10'h000 for the first 1000 starts.
- Noise: freq 16'h8000, wave 4'b1000 → steps 1–15 give 10'h3F8. Steps 112–143 give 10'h3F0. Step 144 gives 10'h3E0, after the 5th bit-19 rise.
- Handshake and reset:
  - Start pulses in READ/CALC/READY are ignored: exactly one ready, and acc advanced once.
  - rst_ni asserted during CALC → no ready. After release, that voice's saw restarts from 1 with freq 16'h4000.
